snake_dir_input: RTL and testbench
==================================

// Module: snake_dir_input
// PURPOSE
// - Front end feeding the snake Core's direction inputs. Turns raw board push-buttons into user_direction and produces random_direction.
// - Sits between the board KEY pins and Core.user_direction / Core.random_direction.
// - Each key is synchronised and debounced; the held key is encoded as a 3-bit direction code.
// - random_direction comes from a free-running 16-bit LFSR.
// PARAMETERS
// - DEB_CYCLES  default 16       stable cycles needed to accept a key change (>=1)
// - LFSR_SEED   default 16'hACE1 LFSR reset value (must be non-zero)
// - RESET_DIR   default 2'b11    last-accepted direction after reset (right)
// PORTS
// - i_clk               in   1  system clock, single clock domain
// - i_rst               in   1  synchronous reset, active-low
// - i_key               in   4  raw buttons, active-low, asynchronous; [0]=up [1]=down [2]=left [3]=right
// - o_user_direction    out  3  3'b100 = no key; 3'b0dd = direction dd (00 up, 01 down, 10 left, 11 right)
// - o_random_direction  out  2  LFSR state bits [1:0]
// BEHAVIOUR
// - Reset (i_rst==0 sampled on a rising edge): sync flops=released (1), debounced state=released, counters=0,
//   o_user_direction=3'b100, last_dir=RESET_DIR, LFSR=LFSR_SEED, o_random_direction=LFSR_SEED[1:0].
// - Reset mid-press discards all debounce progress; a key still held after release of i_rst must re-qualify from scratch.
// - Synchroniser: two flops per key.
// - Debounce, per key:
//   - Counter width $clog2(DEB_CYCLES+1).
//   - Counter increments while the synced level differs from the debounced level, and clears to 0 on any match.
//   - When the counter reaches DEB_CYCLES, the debounced level flips and the counter clears.
//   - A glitch shorter than DEB_CYCLES cycles never reaches the output.
// - Encoder: the lowest-index pressed debounced key wins (up > down > left > right). No key pressed gives 3'b100.
// - Output is registered. Latency from an i_key edge to o_user_direction: 2 (sync) + DEB_CYCLES + 1 cycles.
// - Output level-follows the held key; there is no pulse stretching.
// - last_dir updates to dd whenever a code 3'b0dd is driven.
// - LFSR: Galois right-shift, next = (s>>1) ^ ({16{s[0]}} & 16'hB400).
//   - Advances every cycle out of reset; period 65535.
//   - If the state is ever 0, it reloads LFSR_SEED on the next cycle.
// CONFIGURATION
// - Macro DIR_REVERSE_BLOCK_EN.
// - Defined: a winning direction opposite to last_dir is suppressed and drives 3'b100; last_dir is unchanged.
//   - Opposite means same bit1, different bit0.
//   - A repeat of the same direction is passed through.
// - Undefined: no suppression; every winning key is driven as-is. last_dir is still tracked but unused.
// STRUCTURE
// - Package snake_pkg:
//   - typedef enum logic [1:0] dir_t {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}
//   - localparam logic [2:0] DIR_NONE = 3'b100
//   - function is_opposite(dir_t a, dir_t b)
// - One sub-module, snake_key_debounce: one key's synchroniser plus debounce counter, instantiated 4x via generate.
// - The LFSR and the encoder stay in the top level.
// TESTING
// - Reset: hold i_rst=0 for 3 cycles.
//   -> o_user_direction==3'b100 and o_random_direction==2'b01 during and right after reset.
//   -> Outputs for the next 3 cycles are 2'b00, 2'b00, 2'b00 (states E270, 7138, 389C).
// - Clean press: DEB_CYCLES=4, drive i_key[2]=0 and hold.
//   -> o_user_direction==3'b010 exactly 7 cycles after the edge.
//   -> Returns to 3'b100 7 cycles after release.
// - Bounce: DEB_CYCLES=4, i_key[0] low for 3 cycles then high.
//   -> o_user_direction stays 3'b100 throughout.
// - Simultaneous: i_key[1] and i_key[3] pressed on the same cycle.
//   -> 3'b001. Releasing key1 only -> 3'b011 after debounce latency.
// - Reversal with DIR_REVERSE_BLOCK_EN, RESET_DIR=11: press left (key2).
//   -> 3'b100 while held. Then press up -> 3'b000; then down -> 3'b100.
//   -> Without the macro the same left press gives 3'b010.
// - Mid-debounce reset: assert i_rst for 1 cycle while DEB counter is at 3 of 4.
//   -> Output is 3'b100 and the full latency restarts after reset release.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake direction front end.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  localparam logic [2:0]  DIR_NONE  = 3'b100;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Opposite directions share the axis bit and differ in the sense bit.
  function automatic logic is_opposite(dir_t a, dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_key_debounce.sv
// One push-button: two-flop synchroniser followed by a stable-count debouncer.
// o_level is the debounced raw level (active-low key, 1 = released).
module snake_key_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_level
);

  localparam int              CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The flip happens on the edge that would make the count reach DEB_CYCLES.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = ~level_q;
      else                   cnt_d   = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level = level_q;

endmodule

// File: rtl/snake_dir_input.sv
// Board keys -> registered snake direction code, plus a free-running LFSR direction.
// Define DIR_REVERSE_BLOCK_EN to suppress a direction opposite to the last one driven.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int          DEB_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [1:0]  RESET_DIR  = 2'b11
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_key,
  output logic [2:0] o_user_direction,
  output logic [1:0] o_random_direction
);

  logic [3:0]  deb_n;
  logic        win_valid;
  dir_t        win_dir;
  dir_t        last_q, last_d;
  logic [2:0]  dir_q, dir_d;
  logic [15:0] lfsr_q, lfsr_d;

  for (genvar k = 0; k < 4; k++) begin : g_key
    snake_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_key_n (i_key[k]),
      .o_level (deb_n[k])
    );
  end

  // Lowest-index pressed key wins.
  always_comb begin
    win_valid = 1'b1;
    win_dir   = DIR_UP;
    casez (deb_n)
      4'b???0: win_dir   = DIR_UP;
      4'b??01: win_dir   = DIR_DOWN;
      4'b?011: win_dir   = DIR_LEFT;
      4'b0111: win_dir   = DIR_RIGHT;
      default: win_valid = 1'b0;
    endcase
`ifdef DIR_REVERSE_BLOCK_EN
    if (win_valid && is_opposite(win_dir, last_q)) win_valid = 1'b0;
`endif
    dir_d  = win_valid ? {1'b0, win_dir} : DIR_NONE;
    last_d = win_valid ? win_dir : last_q;
  end

  // Galois right-shift; an all-zero state can never advance, so reload the seed.
  always_comb begin
    if (lfsr_q == '0) lfsr_d = LFSR_SEED;
    else              lfsr_d = (lfsr_q >> 1) ^ ({16{lfsr_q[0]}} & LFSR_TAPS);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      dir_q  <= DIR_NONE;
      last_q <= dir_t'(RESET_DIR);
      lfsr_q <= LFSR_SEED;
    end else begin
      dir_q  <= dir_d;
      last_q <= last_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign o_user_direction   = dir_q;
  assign o_random_direction = lfsr_q[1:0];

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed bench for snake_dir_input with a window-based reference model checked every cycle.
module tb_snake_dir_input;

  localparam int          DEB  = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [1:0]  RDIR = 2'b11;
`ifdef DIR_REVERSE_BLOCK_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key = 4'hF;
  logic [2:0] user_dir;
  logic [1:0] rnd_dir;

  int n_checks = 0;
  int n_pass   = 0;

  snake_dir_input #(.DEB_CYCLES(DEB), .LFSR_SEED(SEED), .RESET_DIR(RDIR)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_key              (key),
    .o_user_direction   (user_dir),
    .o_random_direction (rnd_dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a key's debounced state flips once the last DEB synchronised
  // samples (raw samples two to DEB+1 edges old) all disagree with it.
  logic [3:0]  hist_q [0:DEB];
  logic [3:0]  m_deb_q;
  logic [2:0]  m_out_q;
  logic [1:0]  m_last_q;
  logic [15:0] m_lfsr_q;
  bit          m_valid_q = 1'b0;

  always @(posedge clk) begin : model
    logic [3:0] deb;
    logic [2:0] out;
    logic [1:0] last;
    bit         all_diff;
    if (!rst) begin
      for (int j = 0; j <= DEB; j++) hist_q[j] <= 4'hF;
      m_deb_q  <= 4'hF;
      m_out_q  <= 3'b100;
      m_last_q <= RDIR;
      m_lfsr_q <= SEED;
    end else begin
      out  = 3'b100;
      last = m_last_q;
      for (int i = 3; i >= 0; i--)
        if (!m_deb_q[i]) out = {1'b0, 2'(i)};
      if (!out[2]) begin
        if (REV && out[1] == last[1] && out[0] != last[0]) out = 3'b100;
        else last = out[1:0];
      end
      deb = m_deb_q;
      for (int k = 0; k < 4; k++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DEB; j++)
          if (hist_q[j][k] == m_deb_q[k]) all_diff = 1'b0;
        if (all_diff) deb[k] = ~deb[k];
      end
      for (int j = DEB; j >= 1; j--) hist_q[j] <= hist_q[j-1];
      hist_q[0] <= key;
      m_deb_q   <= deb;
      m_out_q   <= out;
      m_last_q  <= last;
      m_lfsr_q  <= (m_lfsr_q == 16'h0) ? SEED
                 : ((m_lfsr_q >> 1) ^ (m_lfsr_q[0] ? 16'hB400 : 16'h0000));
    end
    m_valid_q <= 1'b1;
  end

  always @(negedge clk) begin : compare
    if (m_valid_q) begin
      check("model_user_dir", 16'(user_dir), 16'(m_out_q));
      check("model_rand_dir", 16'(rnd_dir),  16'(m_lfsr_q[1:0]));
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    step(3);
    rst = 1'b1;
  endtask

  initial begin
    // Reset and LFSR sequence ACE1 -> E270 -> 7138 -> 389C.
    rst = 1'b0;
    key = 4'hF;
    step(1);
    check("rst_during_dir", 16'(user_dir), 16'h4);
    check("rst_during_rnd", 16'(rnd_dir),  16'h1);
    step(2);
    check("rst_after_dir", 16'(user_dir), 16'h4);
    check("rst_after_rnd", 16'(rnd_dir),  16'h1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("lfsr_first3", 16'(rnd_dir), 16'h0);
    end
    check("model_lfsr_389c", m_lfsr_q, 16'h389C);
    step(4);

    // Clean press of left, then release.
    key = 4'b1011;
    step(6);
    check("press_before_lat", 16'(user_dir), 16'h4);
    step(1);
    check("press_at_lat", 16'(user_dir), REV ? 16'h4 : 16'h2);
    step(5);
    key = 4'hF;
    step(6);
    check("release_before_lat", 16'(user_dir), REV ? 16'h4 : 16'h2);
    step(1);
    check("release_at_lat", 16'(user_dir), 16'h4);
    step(3);

    // Bounce: up low for only 3 cycles.
    key = 4'b1110;
    step(3);
    key = 4'hF;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("bounce_no_output", 16'(user_dir), 16'h4);
    end

    // Simultaneous down + right, then release down only.
    do_reset();
    key = 4'b0101;
    step(7);
    check("simul_down_wins", 16'(user_dir), 16'h1);
    step(3);
    key = 4'b0111;
    step(6);
    check("simul_still_down", 16'(user_dir), 16'h1);
    step(1);
    check("simul_right_after", 16'(user_dir), 16'h3);
    key = 4'hF;
    step(10);

    // Reversal sequence from last_dir = right.
    do_reset();
    key = 4'b1011;
    step(7);
    check("rev_left", 16'(user_dir), REV ? 16'h4 : 16'h2);
    step(3);
    check("rev_left_held", 16'(user_dir), REV ? 16'h4 : 16'h2);
    key = 4'b1010;
    step(7);
    check("rev_up", 16'(user_dir), 16'h0);
    key = 4'b1101;
    step(7);
    check("rev_down", 16'(user_dir), REV ? 16'h4 : 16'h1);
    key = 4'hF;
    step(10);

    // Mid-debounce reset: counter at 3 of 4, then a one-cycle reset.
    key = 4'b1110;
    step(5);
    rst = 1'b0;
    step(1);
    check("midrst_during", 16'(user_dir), 16'h4);
    rst = 1'b1;
    step(6);
    check("midrst_before_lat", 16'(user_dir), 16'h4);
    step(1);
    check("midrst_at_lat", 16'(user_dir), 16'h0);
    key = 4'hF;
    step(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
